// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder sequencer around one shared 1-bit full adder
// Optional two's-complement overflow output enabled by defining SERIAL_ADD_OVF_EN.

module serial_add_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_r_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_r_next;

    serial_add_fa u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB result.
    always_comb begin
        w_r_next            = r_r_sh >> 1;
        w_r_next[WIDTH-1]   = w_s;
    end

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_r_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_r_sh  <= w_r_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_r_next;
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // On the last bit the carry FF holds the carry into the MSB.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_ADD && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign Ovf = r_ovf;
`endif

    assign Busy = (r_state == S_ADD);
    assign Done = r_done;
    assign Sum  = r_sum;
    assign Cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH=8)

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             Ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
`ifdef SERIAL_ADD_OVF_EN
        .Ovf   (Ovf),
`endif
        .Cout  (Cout)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one addition, wait for Done, and check latency, hold and result.
    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic [7:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf);
        int n;
        logic [7:0] prev;
        logic hold_ok;
        prev    = Sum;
        hold_ok = 1'b1;
        A = a; B = b; Cin = c; Start = 1'b1;
        step();
        Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        n = 0;
        while (!Done && n < 20) begin
            if (Sum !== prev) hold_ok = 1'b0;
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
        chk({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(Cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 32'(Ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        step();
        chk({tag, "_done_clr"}, 32'(Done), 32'd0);
        chk({tag, "_busy_clr"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int n;
        int ndone;
        int t [0:3];
        logic [7:0] s_first;

        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        chk("rst_sum", 32'(Sum), 32'h00);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(Ovf), 32'd0);
`endif

        run_add("add5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_add("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start re-pulsed three edges into ADD must be ignored
        A = 8'h12; B = 8'h34; Cin = 1'b0; Start = 1'b1;
        step();
        Start = 1'b0;
        step(); step(); step();
        A = 8'h70; B = 8'h70; Cin = 1'b1; Start = 1'b1;
        chk("ign_sum_hold", 32'(Sum), 32'h00);
        step();
        Start = 1'b0;
        ndone = 0;
        s_first = 8'hXX;
        for (int i = 0; i < 16; i++) begin
            if (Done) begin
                if (ndone == 0) s_first = Sum;
                ndone++;
            end
            step();
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_sum", 32'(s_first), 32'h46);

        // Reset on the 4th ADD edge abandons the operation
        A = 8'h0F; B = 8'h01; Cin = 1'b0; Start = 1'b1;
        step();
        Start = 1'b0;
        step(); step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        chk("mid_rst_sum", 32'(Sum), 32'h00);
        chk("mid_rst_cout", 32'(Cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done) ndone++;
            step();
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);

        // Start held high: back-to-back operations every WIDTH+2 cycles
        A = 8'h01; B = 8'h01; Cin = 1'b0; Start = 1'b1;
        ndone = 0;
        n = 0;
        while (ndone < 3 && n < 60) begin
            step();
            n++;
            if (Done) begin
                t[ndone] = n;
                chk("b2b_sum", 32'(Sum), 32'h02);
                ndone++;
            end
        end
        Start = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            chk("b2b_first", 32'(t[0]), 32'd9);
            chk("b2b_gap1", 32'(t[1] - t[0]), 32'd10);
            chk("b2b_gap2", 32'(t[2] - t[1]), 32'd10);
        end
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that time-shares one 1-bit full adder (A, B, Cin -> S, Cout) to add two WIDTH-bit operands bit-serially, LSB first.
- Loads the operands on a start request and steps the adder one bit per clock, holding the carry in a flip-flop between bits.
- Presents the registered result with a Busy/Done handshake.
- Sits between a register-file/user-input front end and the display path in the lab datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- Start  input  1  request a new addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepted-Start edge.
- B  input  WIDTH  operand B; captured on the accepted-Start edge.
- Cin  input  1  carry-in; captured on the accepted-Start edge.
- Busy  output  1  high while an addition is in progress (state ADD).
- Done  output  1  single-cycle pulse when Sum/Cout are updated.
- Sum  output  WIDTH  registered result; holds the last result until the next completion.
- Cout  output  1  registered carry-out of the MSB; same update rule as Sum.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST); no other clock or async path.
- Reset: state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, shift registers=0, carry FF=0, bit counter=0.
- RST dominates every other input on the same edge, including mid-operation: the current addition is abandoned and no Done is issued.
- States:
  - IDLE:
    - Start=1 -> load A_sh=A, B_sh=B, carry=Cin, cnt=0, go to ADD.
    - Start=0 -> stay in IDLE.
  - ADD, each edge:
    - Drive the full adder with A_sh[0], B_sh[0] and the carry FF.
    - Shift S into R_sh at the MSB (right shift).
    - Shift A_sh and B_sh right by 1.
    - carry <= adder Cout; cnt <= cnt+1.
    - When cnt==WIDTH-1 on an edge: Sum <= final R_sh value including this bit, Cout <= adder Cout, Done <= 1, go to DONE.
  - DONE: Done=1 for exactly this one cycle; next edge Done <= 0 and go to IDLE unconditionally.
- Start handling:
  - Start in ADD or DONE is ignored, not queued; it must be held or re-asserted in IDLE.
  - The A, B and Cin input pins are don't-care outside the accepted-Start edge.
- Busy is combinational from state: (state==ADD).
- Latency: Start accepted at edge e0 -> Done visible after edge eWIDTH, for one cycle -> next Start accepted no earlier than edge eWIDTH+2.
- Throughput: one addition per WIDTH+2 cycles.
- The bit counter is ceil(log2(WIDTH))+1 bits wide. It never wraps inside an operation.
- Sum and Cout keep their previous values for the whole of ADD. They change only on the completion edge or on reset.
- WIDTH=1: a single ADD cycle, then DONE.
- The full adder is a separate instantiated combinational block; the controller does not inline the sum/carry logic.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit): two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB.
  - Ovf is registered on the same completion edge as Sum and Cout.
  - Ovf resets to 0 and holds between operations.
- Undefined: the Ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, RST high for 2 cycles -> Sum=0x00, Cout=0, Busy=0, Done=0. Then Start=1 for one cycle with A=0x5A, B=0x33, Cin=0 -> Busy high for 8 cycles, Done pulses once 8 edges after Start, Sum=0x8D, Cout=0; Ovf=1 if SERIAL_ADD_OVF_EN.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; Ovf=0.
- A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1. A=0x80, B=0x80, Cin=0 -> Sum=0x00, Cout=1, Ovf=1.
- Start pulsed again 3 cycles into ADD with different operands -> ignored: only one Done, result equals the first operands. Sum holds its previous value throughout ADD.
- RST asserted on the 4th ADD edge -> next edge state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, and no Done pulse follows.
- Start held high continuously with A=0x01, B=0x01, Cin=0 -> back-to-back operations, Done pulses spaced exactly 10 cycles apart, Sum=0x02 each time.
